// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. The line is double-flopped, a falling edge
// starts a frame, and every bit is sampled at its centre. A correctly framed
// byte is presented on RX_DATA together with a sticky rdy flag.
//
// Handshake: rdy rises on the clock after a good stop bit is sampled and
// stays high until the consumer pulses clr_rdy for one or more cycles. When a
// byte completes in the same cycle as clr_rdy, the new byte wins and rdy
// stays 1. A byte completing while rdy is still 1 overwrites RX_DATA and
// sets ovr_err, which clr_rdy also clears.
module uart_rx #(
  parameter int BAUD_DIV = 110,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] RX_DATA,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2
  } state_t;

  localparam logic [6:0] HALF_LAST = 7'(HALF_DIV - 1);
  localparam logic [6:0] BAUD_LAST = 7'(BAUD_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_d;
  logic [6:0]  baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        start_edge;
  logic        strobe;
  logic        data_strobe;
  logic        stop_strobe;
  logic        set_rdy;
  logic        set_frm;

  assign state_dbg  = state;
  assign start_edge = rx_d & ~rx_s;

  // Sample strobes: half a bit into the start bit, then a full bit period
  // for each data bit and the stop bit. bit_cnt == 8 marks the stop bit.
  always_comb begin
    strobe      = 1'b0;
    data_strobe = 1'b0;
    stop_strobe = 1'b0;
    if (state == START && baud_cnt == HALF_LAST) begin
      strobe = 1'b1;
    end
    if (state == RECV && baud_cnt == BAUD_LAST) begin
      strobe = 1'b1;
      if (bit_cnt == 4'd8) begin
        stop_strobe = 1'b1;
      end else begin
        data_strobe = 1'b1;
      end
    end
    set_rdy = stop_strobe & rx_s;
    set_frm = stop_strobe & ~rx_s;
  end

  // Two-flop synchroniser plus one delay flop for edge detection; reset to
  // the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A start bit that reads high at its centre is a glitch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (strobe) state_nxt = rx_s ? IDLE : RECV;
      RECV:    if (stop_strobe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter: held at zero in IDLE so a start edge always begins at 0,
  // restarted on every sample strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (state == IDLE || strobe) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 7'd1;
    end
  end

  // Bit counter: cleared when the start bit is confirmed, steps per data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state == START && strobe) begin
      bit_cnt <= '0;
    end else if (data_strobe) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Shift register: data arrives LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (data_strobe) begin
      shreg <= {rx_s, shreg[7:1]};
    end
  end

  // Output flags and data. A new byte takes priority over clr_rdy; overrun is
  // judged against rdy as it stood before any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      RX_DATA <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      frm_err <= set_frm;
      if (set_rdy) begin
        RX_DATA <= shreg;
        rdy     <= 1'b1;
        ovr_err <= rdy | (ovr_err & ~clr_rdy);
      end else if (clr_rdy) begin
        rdy     <= 1'b0;
        ovr_err <= 1'b0;
      end
    end
  end

endmodule
